// File: rtl/mem_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_pkg
// Description : Shared types and constants for the memory-stage controller.
//               Contains the FSM state type, the bit positions inside the
//               2-bit write-back control field, and the mask that flags a
//               misaligned word address.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Any set bit under this mask means the address is not word aligned.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

endpackage : mem_stage_ctrl_pkg
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_reg
// Description : MEM/WB pipeline register with load enable and bubble insert.
//               i_load    : capture the incoming instruction this edge
//               i_squash  : capture it, but with write-back control cleared
//               i_rd_load : also capture memory read data (ack edge)
//               When i_load is low, a bubble is inserted: write-back control
//               goes to zero and every other field keeps its value.
//               Outputs o_wb / o_rdata / o_aluout / o_rdaddr are the
//               MEM/WB fields seen by write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic        i_squash,
    input  logic        i_rd_load,
    input  logic [1:0]  i_wb,
    input  logic [31:0] i_aluout,
    input  logic [4:0]  i_rdaddr,
    input  logic [31:0] i_rdata,
    output logic [1:0]  o_wb,
    output logic [31:0] o_rdata,
    output logic [31:0] o_aluout,
    output logic [4:0]  o_rdaddr
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb     <= 2'b00;
            o_rdata  <= 32'd0;
            o_aluout <= 32'd0;
            o_rdaddr <= 5'd0;
        end else if (i_load) begin
            // A squashed instruction still flows through but never writes back.
            o_wb[WB_REGWRITE] <= i_wb[WB_REGWRITE] & ~i_squash;
            o_wb[WB_MEMTOREG] <= i_wb[WB_MEMTOREG] & ~i_squash;
            o_aluout          <= i_aluout;
            o_rdaddr          <= i_rdaddr;
            if (i_rd_load) begin
                o_rdata <= i_rdata;
            end
        end else begin
            o_wb <= 2'b00;
        end
    end

endmodule : mem_wb_reg
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage controller. Turns EX/MEM load/store requests
//               into a registered req/ack memory transaction, stalls the
//               front of the pipeline while the access is outstanding,
//               aborts accesses that exceed TIMEOUT request cycles, and
//               terminates the stage in a MEM/WB register.
// Ports       : clk_i/rst_i          - clock, async active-high reset
//               MEMR_i/MEMW_i/WB_i/ALUout_i/RS2_i/RDaddr_i - EX/MEM fields
//               stall_o              - hold upstream pipeline (combinational)
//               mem_req_o/we/addr/wdata, mem_ack_i/mem_rdata_i - memory port
//               WB_o/rdata_o/ALUout_o/RDaddr_o - MEM/WB fields
//               err_o                - sticky misaligned/timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MEMR_i,
    input  logic        MEMW_i,
    input  logic [1:0]  WB_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] RS2_i,
    input  logic [4:0]  RDaddr_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  WB_o,
    output logic [31:0] rdata_o,
    output logic [31:0] ALUout_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mem_req;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_err;

    logic               w_access;
    logic               w_aligned;
    logic               w_start;
    logic               w_misalign;
    logic               w_ack;
    logic               w_timeout;
    logic               w_stall;

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_access    = MEMR_i | MEMW_i;
        w_aligned   = (ALUout_i[1:0] & MISALIGN_MASK) == 2'b00;
        w_start     = (r_state == IDLE) & w_access & w_aligned;
        w_misalign  = (r_state == IDLE) & w_access & ~w_aligned;
        // Acks outside REQ are stray and must not complete anything.
        w_ack       = (r_state == REQ) & mem_ack_i;
        // An ack in the final counted cycle wins over the timeout.
        w_timeout   = (r_state == REQ) & ~mem_ack_i & (r_cnt == c_CNT_LAST);
        // Gated by reset so the pipeline is never held while in reset.
        w_stall     = ~rst_i & (w_start | ((r_state == REQ) & ~mem_ack_i & ~w_timeout));
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = REQ;
            REQ:  if (w_ack | w_timeout) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, timeout counter and request registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                // A simultaneous read+write request is issued as a store.
                r_mem_req   <= 1'b1;
                r_mem_we    <= MEMW_i;
                r_mem_addr  <= ALUout_i;
                r_mem_wdata <= RS2_i;
                r_cnt       <= '0;
            end else if (r_state == REQ) begin
                if (w_ack | w_timeout) begin
                    r_mem_req <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_misalign | w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    mem_wb_reg u_mem_wb_reg (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_load    (~w_stall),
        .i_squash  (w_misalign | w_timeout),
        .i_rd_load (w_ack),
        .i_wb      (WB_i),
        .i_aluout  (ALUout_i),
        .i_rdaddr  (RDaddr_i),
        .i_rdata   (mem_rdata_i),
        .o_wb      (WB_o),
        .o_rdata   (rdata_o),
        .o_aluout  (ALUout_o),
        .o_rdaddr  (RDaddr_o)
    );

    assign stall_o     = w_stall;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign err_o       = r_err;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. Each instruction is
//               described at transaction level (kind, address, ack latency)
//               and the expected stall/request profile and MEM/WB result are
//               derived from latency arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam int c_TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MEMR_i, MEMW_i;
    logic [1:0]  WB_i;
    logic [31:0] ALUout_i, RS2_i;
    logic [4:0]  RDaddr_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  WB_o;
    logic [31:0] rdata_o, ALUout_o;
    logic [4:0]  RDaddr_o;
    logic        err_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_rdata;
    logic        m_err;

    mem_stage_ctrl #(.TIMEOUT(c_TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MEMR_i      (MEMR_i),
        .MEMW_i      (MEMW_i),
        .WB_i        (WB_i),
        .ALUout_i    (ALUout_i),
        .RS2_i       (RS2_i),
        .RDaddr_i    (RDaddr_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .WB_o        (WB_o),
        .rdata_o     (rdata_o),
        .ALUout_o    (ALUout_o),
        .RDaddr_o    (RDaddr_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One instruction through the stage. k = REQ cycle (1-based) in which
    // the memory acks; k outside 1..c_TO means the memory never answers.
    // Called 1 time unit after a rising edge.
    task automatic run_instr(input bit rd, input bit wr, input logic [1:0] wb,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input logic [4:0] rdst, input int k,
                             input logic [31:0] rdat);
        bit acc, mis, acked, squash;
        int lat;
        acc    = rd | wr;
        mis    = acc && (addr[1:0] != 2'b00);
        acked  = acc && !mis && (k >= 1) && (k <= c_TO);
        squash = mis || (acc && !mis && !acked);
        // Number of stalled cycles = number of REQ cycles used.
        if (!acc || mis) lat = 0;
        else if (acked)  lat = k;
        else             lat = c_TO;
        MEMR_i = rd; MEMW_i = wr; WB_i = wb;
        ALUout_i = addr; RS2_i = wdat; RDaddr_i = rdst;
        for (int j = 0; j <= lat; j++) begin
            if (acc && !mis) begin
                mem_ack_i   = acked && (j == k);
                mem_rdata_i = (acked && j == k) ? rdat : $urandom;
            end else begin
                // Stray acks while idle must be ignored.
                mem_ack_i   = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
            end
            #4;
            chk("stall", 32'(stall_o), 32'(j < lat));
            chk("req", 32'(mem_req_o), 32'(j >= 1));
            if (j >= 1) begin
                chk("we", 32'(mem_we_o), 32'(wr));
                chk("addr", mem_addr_o, addr);
                if (wr) chk("wdata", mem_wdata_o, wdat);
                chk("wb_bubble", 32'(WB_o), 32'd0);
            end
            @(posedge clk_i);
            #1;
        end
        mem_ack_i = 1'b0;
        if (acked)  m_rdata = rdat;
        if (squash) m_err   = 1'b1;
        chk("wb_o", 32'(WB_o), squash ? 32'd0 : 32'(wb));
        chk("aluout_o", ALUout_o, addr);
        chk("rdaddr_o", 32'(RDaddr_o), 32'(rdst));
        chk("rdata_o", rdata_o, m_rdata);
        chk("err_o", 32'(err_o), 32'(m_err));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_req"}, 32'(mem_req_o), 32'd0);
        chk({tag, "_wb"}, 32'(WB_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; MEMR_i = 1'b0; MEMW_i = 1'b0; WB_i = 2'b00;
        ALUout_i = 32'd0; RS2_i = 32'd0; RDaddr_i = 5'd0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
        m_rdata = 32'd0; m_err = 1'b0;
        repeat (2) @(posedge clk_i);
        // Access presented during reset must not stall.
        MEMR_i = 1'b1; ALUout_i = 32'h40;
        #4;
        check_zero("reset");
        chk("reset_we", 32'(mem_we_o), 32'd0);
        chk("reset_addr", mem_addr_o, 32'd0);
        chk("reset_wdata", mem_wdata_o, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_alu", ALUout_o, 32'd0);
        chk("reset_rd", 32'(RDaddr_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Directed cases
        run_instr(1'b0, 1'b0, 2'b10, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        run_instr(1'b1, 1'b0, 2'b11, 32'h100, 32'h0, 5'd6, 3, 32'hDEADBEEF);
        run_instr(1'b0, 1'b1, 2'b00, 32'h200, 32'hCAFEF00D, 5'd0, 1, 32'h11111111);
        run_instr(1'b1, 1'b1, 2'b00, 32'h204, 32'h55AA55AA, 5'd0, c_TO, 32'h22222222);
        run_instr(1'b1, 1'b0, 2'b11, 32'h102, 32'h0, 5'd7, 1, 32'h0);
        run_instr(1'b1, 1'b0, 2'b11, 32'h300, 32'h0, 5'd8, c_TO + 1, 32'h0);
        // Late ack after the timeout, in idle cycles
        run_instr(1'b0, 1'b0, 2'b10, 32'h4, 32'h0, 5'd9, 0, 32'h0);
        run_instr(1'b0, 1'b0, 2'b10, 32'h8, 32'h0, 5'd10, 0, 32'h0);

        // Reset during the second REQ cycle
        MEMR_i = 1'b1; MEMW_i = 1'b0; WB_i = 2'b11; ALUout_i = 32'h400;
        RDaddr_i = 5'd3; mem_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check_zero("midreq_rst");
        MEMR_i = 1'b0; mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        m_rdata = 32'd0; m_err = 1'b0;
        run_instr(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 0, 32'h0);
        run_instr(1'b1, 1'b0, 2'b11, 32'h500, 32'h0, 5'd4, 2, 32'h0BADF00D);

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a    = {$urandom, 2'b00} >> 0;
            a[1:0] = 2'b00;
            if (kind == 4) a[1:0] = 2'($urandom_range(1, 3));
            run_instr(kind == 1 || kind == 3 || kind == 4,
                      kind == 2 || kind == 3,
                      2'($urandom_range(0, 3)), a, $urandom,
                      5'($urandom_range(0, 31)),
                      $urandom_range(1, c_TO + 1), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_stage_ctrl
`default_nettype wire
